dispatch_queue: RTL and testbench

- Parametrised N-wide in-order dispatch stage between rename and issue/ROB enqueue.
- Buffers renamed uops in a circular queue and allocates ROB indices (index plus wrap flag) at dispatch.
- Throttles dispatch on free ROB entries and per-lane issue back-pressure.
- Discards all buffered state on a pipeline flush.

---
 rtl/dispatch_pkg.sv | 50 +++++
 rtl/dispatch_rob_alloc.sv | 56 +++++
 rtl/dispatch_queue.sv | 138 +++++++++++++
 tb/tb_dispatch_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the dispatch stage: ROB pointer arithmetic and lane-run counting.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dispatch_pkg;

    // Default configuration, defined once for the whole codebase.
    localparam int DFLT_WIDTH        = 2;
    localparam int DFLT_DEPTH        = 8;
    localparam int DFLT_ROB_SIZE_LOG = 6;

    // Widest dispatch group supported; lane vectors are zero-padded to this width for the helpers.
    localparam int MAX_WIDTH = 4;

    // ROB pointer: index plus a wrap flag that toggles each time the index wraps.
    typedef struct packed {
        logic                         flag;
        logic [DFLT_ROB_SIZE_LOG-1:0] idx;
    } rob_ptr_t;

    // Advance a ROB pointer by n. The carry out of idx lands in flag, which is exactly the wrap toggle.
    function automatic rob_ptr_t rob_ptr_add(input rob_ptr_t ptr, input logic [2:0] n);
        logic [DFLT_ROB_SIZE_LOG:0] sum;
        sum = ptr + {{(DFLT_ROB_SIZE_LOG-2){1'b0}}, n};
        return rob_ptr_t'(sum);
    endfunction

    // Length of the run of ones starting at bit 0.
    function automatic logic [2:0] lead_ones(input logic [MAX_WIDTH-1:0] vec);
        logic [2:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            run = run & vec[i];
            n   = n + {2'b00, run};
        end
        return n;
    endfunction

    // Number of set bits.
    function automatic logic [2:0] popcount(input logic [MAX_WIDTH-1:0] vec);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n = n + {2'b00, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dispatch_rob_alloc.sv
// ROB index allocator: holds the ROB enqueue pointer and hands out consecutive indices per lane.
// Latency: lane indices are combinational from the pointer; the pointer advances one cycle after dispatch.
// Backpressure: none of its own; advances only by the dispatched count, reloads on flush.
module dispatch_rob_alloc
    import dispatch_pkg::*;
#(
    parameter int WIDTH = DFLT_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               flush_flag,
    input  logic [DFLT_ROB_SIZE_LOG-1:0]       flush_idx,
    input  logic [2:0]                         deq_n,
    output logic [WIDTH-1:0]                   lane_flag,
    output logic [WIDTH*DFLT_ROB_SIZE_LOG-1:0] lane_idx
);

    localparam int RL = DFLT_ROB_SIZE_LOG;

    rob_ptr_t ptr_q, ptr_d;
    rob_ptr_t lane_ptr;

    // Next pointer: a flush reload wins, otherwise step past the uops dispatched this cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (flush) begin
            ptr_d.flag = flush_flag;
            ptr_d.idx  = flush_idx;
        end else begin
            ptr_d = rob_ptr_add(ptr_q, deq_n);
        end
    end

    // Pointer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Lane i is offered pointer+i; lanes past a wrap see the toggled flag.
    always_comb begin
        lane_ptr  = '0;
        lane_flag = '0;
        lane_idx  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_ptr             = rob_ptr_add(ptr_q, 3'(i));
            lane_flag[i]         = lane_ptr.flag;
            lane_idx[i*RL +: RL] = lane_ptr.idx;
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order N-wide dispatch queue between rename and issue/ROB enqueue, allocating ROB indices at dispatch.
// Latency: one cycle minimum from enqueue to output visibility; no bypass path.
// Backpressure: in_ready from registered count only; per-lane out_ready consumed as a leading run; ROB free count throttles.
module dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int WIDTH        = DFLT_WIDTH,
    parameter int DEPTH        = DFLT_DEPTH,
    parameter int PAYLOAD_W    = 160,
    parameter int ROB_SIZE_LOG = DFLT_ROB_SIZE_LOG
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          flush_robidx_flag,
    input  logic [ROB_SIZE_LOG-1:0]       flush_robidx,
    input  logic [WIDTH-1:0]              in_valid,
    input  logic [WIDTH*PAYLOAD_W-1:0]    in_payload,
    output logic                          in_ready,
    input  logic [ROB_SIZE_LOG:0]         rob_free_cnt,
    output logic [WIDTH-1:0]              out_valid,
    input  logic [WIDTH-1:0]              out_ready,
    output logic [WIDTH*PAYLOAD_W-1:0]    out_payload,
    output logic [WIDTH-1:0]              out_robidx_flag,
    output logic [WIDTH*ROB_SIZE_LOG-1:0] out_robidx,
    output logic [$clog2(DEPTH):0]        occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = ROB_SIZE_LOG + 1;

    // The ROB pointer type is sized centrally; any other ROB width or lane count is not supported.
    if (ROB_SIZE_LOG != DFLT_ROB_SIZE_LOG || WIDTH < 1 || WIDTH > MAX_WIDTH || DEPTH < 2*WIDTH) begin : g_bad_cfg
        $error("dispatch_queue: unsupported parameter set");
    end

    logic [PAYLOAD_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;

    logic [CW-1:0]        free_slots;
    logic [MAX_WIDTH-1:0] in_vec;
    logic [MAX_WIDTH-1:0] hs_vec;
    logic [2:0]           enq_n;
    logic [2:0]           deq_n;
    logic [WIDTH-1:0]     wr_en;
    logic [PW-1:0]        wr_addr [WIDTH];

    // Accept a whole group only when a full group's worth of slots is free in the registered count.
    always_comb begin
        free_slots = CW'(DEPTH) - count_q;
        in_ready   = !reset && !flush && (free_slots >= CW'(WIDTH));
        in_vec     = '0;
        in_vec[WIDTH-1:0] = in_valid;
        enq_n      = in_ready ? popcount(in_vec) : 3'd0;
        for (int i = 0; i < WIDTH; i++) begin
            wr_en[i]   = in_ready && in_valid[i];
            wr_addr[i] = tail_q + PW'(i);
        end
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_addr[i]] <= in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Head lanes are offered while entries exist and the ROB has room for that lane.
    always_comb begin
        out_valid   = '0;
        out_payload = '0;
        hs_vec      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_valid[i] = !reset && !flush && (count_q > CW'(i)) && (rob_free_cnt > FW'(i));
            out_payload[i*PAYLOAD_W +: PAYLOAD_W] = mem_q[head_q + PW'(i)];
        end
        hs_vec[WIDTH-1:0] = out_valid & out_ready;
        // A ready lane behind a stalled lane must wait, so only the leading run counts.
        deq_n = lead_ones(hs_vec);
    end

    // Pointer and count update; flush discards everything and rewinds to slot 0.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(deq_n);
            tail_d  = tail_q + PW'(enq_n);
            count_d = count_q + CW'(enq_n) - CW'(deq_n);
        end
    end

    // Queue control registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign occupancy = count_q;

    dispatch_rob_alloc #(
        .WIDTH (WIDTH)
    ) u_rob_alloc (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .flush_flag (flush_robidx_flag),
        .flush_idx  (flush_robidx),
        .deq_n      (deq_n),
        .lane_flag  (out_robidx_flag),
        .lane_idx   (out_robidx)
    );

    // Rename must present valid lanes as a contiguous prefix starting at lane 0.
    a_in_valid_prefix: assert property (
        @(posedge clock) disable iff (reset)
        ((in_valid & (in_valid + WIDTH'(1))) == '0)
    );

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue with a scoreboard of expected dispatched uops.
// Stimulus pushes expected payload/ROB pointer per accepted uop; a monitor pops on each completed handshake.
// Direct checks cover in_ready, out_valid, occupancy and the ROB pointer after flush/reset.
module tb_dispatch_queue;

    localparam int W  = 2;
    localparam int D  = 8;
    localparam int P  = 160;
    localparam int RL = 6;

    logic           clock;
    logic           reset;
    logic           flush;
    logic           flush_robidx_flag;
    logic [RL-1:0]  flush_robidx;
    logic [W-1:0]   in_valid;
    logic [W*P-1:0] in_payload;
    logic           in_ready;
    logic [RL:0]    rob_free_cnt;
    logic [W-1:0]   out_valid;
    logic [W-1:0]   out_ready;
    logic [W*P-1:0] out_payload;
    logic [W-1:0]   out_robidx_flag;
    logic [W*RL-1:0] out_robidx;
    logic [3:0]     occupancy;

    dispatch_queue #(
        .WIDTH(W), .DEPTH(D), .PAYLOAD_W(P), .ROB_SIZE_LOG(RL)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .flush_robidx_flag (flush_robidx_flag),
        .flush_robidx      (flush_robidx),
        .in_valid          (in_valid),
        .in_payload        (in_payload),
        .in_ready          (in_ready),
        .rob_free_cnt      (rob_free_cnt),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_payload       (out_payload),
        .out_robidx_flag   (out_robidx_flag),
        .out_robidx        (out_robidx),
        .occupancy         (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [P-1:0] pay;
        logic [RL:0]  rob;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          mcount   = 0;
    int          next_id  = 0;
    logic [RL:0] exp_ptr  = '0;

    function automatic logic [P-1:0] mk_pay(input int id);
        logic [31:0] w;
        w = 32'hD00D_0000 + 32'(id);
        return {w, ~w, w ^ 32'h5A5A_5A5A, w, ~w};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on the falling edge, pop one expected uop for every lane in the leading handshake run.
    logic [W-1:0] mon_hs;
    int           mon_n;
    exp_t         mon_e;
    initial begin
        forever begin
            @(negedge clock);
            mon_hs = out_valid & out_ready;
            mon_n  = 0;
            if (mon_hs[0]) begin
                mon_n = 1;
                if (mon_hs[1]) mon_n = 2;
            end
            for (int i = 0; i < mon_n; i++) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: lane %0d dispatched with nothing expected at %0t", i, $time);
                end else begin
                    mon_e = sb.pop_front();
                    checks++;
                    if (out_payload[i*P +: P] !== mon_e.pay) begin
                        failures++;
                        $display("FAIL payload lane%0d: got %0h expected %0h at %0t",
                                 i, out_payload[i*P +: P], mon_e.pay, $time);
                    end
                    chk($sformatf("robidx lane%0d", i),
                        32'({out_robidx_flag[i], out_robidx[i*RL +: RL]}), 32'(mon_e.rob));
                end
            end
        end
    end

    // One cycle of stimulus with the bench's own model of acceptance, valid lanes and dispatch count.
    task automatic cyc(input logic fl, input logic [1:0] iv, input logic [1:0] ordy,
                       input int free, input logic [RL:0] fptr);
        logic       exp_rdy;
        logic [1:0] exp_ov;
        int         enq;
        int         deq;
        exp_t       e;
        flush             = fl;
        flush_robidx_flag = fptr[RL];
        flush_robidx      = fptr[RL-1:0];
        in_valid          = iv;
        out_ready         = ordy;
        rob_free_cnt      = 7'(free);
        in_payload        = {mk_pay(next_id + 1), mk_pay(next_id)};

        exp_rdy   = !fl && ((D - mcount) >= W);
        exp_ov[0] = !fl && (mcount > 0) && (free > 0);
        exp_ov[1] = !fl && (mcount > 1) && (free > 1);
        enq = exp_rdy ? (int'(iv[0]) + int'(iv[1])) : 0;
        deq = (exp_ov[0] && ordy[0]) ? ((exp_ov[1] && ordy[1]) ? 2 : 1) : 0;
        for (int k = 0; k < enq; k++) begin
            e.pay = mk_pay(next_id + k);
            e.rob = exp_ptr;
            sb.push_back(e);
            exp_ptr = exp_ptr + 7'd1;
        end
        next_id += enq;

        #2;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("occupancy", 32'(occupancy), 32'(mcount));

        if (fl) begin
            mcount  = 0;
            sb.delete();
            exp_ptr = fptr;
        end else begin
            mcount = mcount + enq - deq;
        end
        @(posedge clock);
        #1;
    endtask

    // Lane ROB pointers are visible regardless of valid; check them against the model pointer.
    task automatic chk_rob(input string tag);
        chk({tag, " rob lane0"}, 32'({out_robidx_flag[0], out_robidx[0 +: RL]}), 32'(exp_ptr));
        chk({tag, " rob lane1"}, 32'({out_robidx_flag[1], out_robidx[RL +: RL]}), 32'(exp_ptr + 7'd1));
    endtask

    initial begin
        reset             = 1'b1;
        flush             = 1'b0;
        flush_robidx_flag = 1'b0;
        flush_robidx      = '0;
        in_valid          = '0;
        in_payload        = '0;
        rob_free_cnt      = 7'd64;
        out_ready         = '0;

        #2;
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset occupancy", 32'(occupancy), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_rob("post-reset");

        // Basic flow: two uops per cycle, everything ready.
        repeat (4) cyc(1'b0, 2'b11, 2'b11, 64, '0);
        cyc(1'b0, 2'b00, 2'b11, 64, '0);

        // Partial ready: lane1-only ready consumes nothing, lane0-only ready consumes one.
        cyc(1'b0, 2'b11, 2'b00, 64, '0);
        cyc(1'b0, 2'b00, 2'b10, 64, '0);
        cyc(1'b0, 2'b00, 2'b01, 64, '0);
        cyc(1'b0, 2'b00, 2'b11, 64, '0);

        // ROB throttle: one free entry exposes only lane0; zero free fills the queue.
        cyc(1'b0, 2'b11, 2'b00, 64, '0);
        cyc(1'b0, 2'b11, 2'b00, 64, '0);
        cyc(1'b0, 2'b00, 2'b00, 1, '0);
        cyc(1'b0, 2'b11, 2'b11, 0, '0);
        cyc(1'b0, 2'b11, 2'b11, 0, '0);
        cyc(1'b0, 2'b11, 2'b11, 0, '0);
        // Full queue dequeuing: in_ready stays low this cycle.
        cyc(1'b0, 2'b11, 2'b11, 64, '0);
        cyc(1'b0, 2'b11, 2'b11, 64, '0);
        cyc(1'b0, 2'b00, 2'b11, 1, '0);
        repeat (4) cyc(1'b0, 2'b00, 2'b11, 64, '0);

        // ROB wrap: flush to {0,62}, then four uops straddle the wrap.
        cyc(1'b1, 2'b00, 2'b00, 64, {1'b0, 6'd62});
        chk_rob("flush62");
        cyc(1'b0, 2'b11, 2'b11, 64, '0);
        cyc(1'b0, 2'b11, 2'b11, 64, '0);
        cyc(1'b0, 2'b00, 2'b11, 64, '0);
        cyc(1'b0, 2'b00, 2'b11, 64, '0);

        // Flush mid-stream with five entries and an offered group.
        cyc(1'b0, 2'b11, 2'b00, 64, '0);
        cyc(1'b0, 2'b11, 2'b00, 64, '0);
        cyc(1'b0, 2'b01, 2'b00, 64, '0);
        cyc(1'b1, 2'b11, 2'b11, 64, {1'b1, 6'd5});
        chk_rob("flush5");
        cyc(1'b0, 2'b11, 2'b11, 64, '0);
        cyc(1'b0, 2'b00, 2'b11, 64, '0);
        cyc(1'b0, 2'b00, 2'b11, 64, '0);

        // Asynchronous reset between edges with six entries buffered.
        repeat (3) cyc(1'b0, 2'b11, 2'b00, 64, '0);
        in_valid  = '0;
        out_ready = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("async in_ready", 32'(in_ready), 32'd0);
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async occupancy", 32'(occupancy), 32'd0);
        sb.delete();
        mcount  = 0;
        exp_ptr = '0;
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_rob("after async reset");
        cyc(1'b0, 2'b11, 2'b11, 64, '0);
        cyc(1'b0, 2'b00, 2'b11, 64, '0);
        cyc(1'b0, 2'b00, 2'b00, 64, '0);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
